// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM state encoding,
// datapath widths and the instruction-memory vector location.
package intr_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    // Instruction-memory word that holds the ISR start address.
    localparam logic [DATA_W-1:0] VECTOR_ADDR = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DRAIN      = 3'd1,
        S_PUSH_PC    = 3'd2,
        S_PUSH_FLAGS = 3'd3,
        S_ACK        = 3'd4,
        S_ACTIVE     = 3'd5
    } intr_state_t;

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchroniser for the external interrupt pin plus a history flop,
// giving a one-cycle pulse on each synchronised rising edge.
module intr_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic req_pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign req_pulse = s2 & ~s3;

endmodule

// File: rtl/intr_controller.sv
// Interrupt entry sequencer: freezes fetch, drains the pipe, pushes return PC and
// flags, pulses intr_ack with the vector address selected, then holds until RTI.
module intr_controller
    import intr_pkg::*;
#(
    parameter int FLAG_W = intr_pkg::FLAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intr_in,
    input  logic [DATA_W-1:0] pc,
    input  logic [FLAG_W-1:0] flags,
    input  logic              branch_pending,
    input  logic              pipe_empty,
    input  logic              rti_retire,
    input  logic              push_ready,
    output logic              f_stall_req,
    output logic              imem_addr_sel,
    output logic              intr_ack,
    output logic              intr_active,
    output logic              push_valid,
    output logic [DATA_W-1:0] push_data,
    output intr_state_t       state_dbg
);

    // Push handshake: a stack word transfers on the rising edge where push_valid
    // and push_ready are both 1; while push_ready is 0 the request and data hold.

    intr_state_t       state;
    intr_state_t       state_nxt;
    logic              req_pulse;
    logic              pending;
    logic [DATA_W-1:0] ret_pc;
    logic [FLAG_W-1:0] ret_flags;

    intr_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (intr_in),
        .req_pulse (req_pulse)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (req_pulse || pending) state_nxt = S_DRAIN;
            S_DRAIN:      if (!branch_pending && pipe_empty) state_nxt = S_PUSH_PC;
            S_PUSH_PC:    if (push_ready) state_nxt = S_PUSH_FLAGS;
            S_PUSH_FLAGS: if (push_ready) state_nxt = S_ACK;
            S_ACK:        state_nxt = S_ACTIVE;
            S_ACTIVE:     if (rti_retire) state_nxt = (pending || req_pulse) ? S_DRAIN : S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            ret_pc        <= '0;
            ret_flags     <= '0;
            f_stall_req   <= 1'b0;
            imem_addr_sel <= 1'b0;
            intr_ack      <= 1'b0;
            intr_active   <= 1'b0;
            push_valid    <= 1'b0;
            push_data     <= '0;
        end else begin
            state <= state_nxt;

            if (state_nxt == S_DRAIN && state != S_DRAIN) begin
                pending <= 1'b0;
            end else if (req_pulse && state != S_IDLE) begin
                pending <= 1'b1;
            end

            if (state == S_DRAIN && state_nxt == S_PUSH_PC) begin
                ret_pc    <= pc;
                ret_flags <= flags;
            end

            f_stall_req   <= (state_nxt inside {S_DRAIN, S_PUSH_PC, S_PUSH_FLAGS});
            push_valid    <= (state_nxt inside {S_PUSH_PC, S_PUSH_FLAGS});
            imem_addr_sel <= (state_nxt == S_ACK);
            intr_ack      <= (state_nxt == S_ACK);
            intr_active   <= (state_nxt == S_ACTIVE);

            // On DRAIN exit ret_pc is being loaded this same edge, so forward pc.
            case (state_nxt)
                S_PUSH_PC:    push_data <= (state == S_DRAIN) ? pc : ret_pc;
                S_PUSH_FLAGS: push_data <= {{(DATA_W-FLAG_W){1'b0}}, ret_flags};
                default:      push_data <= '0;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: table vectors, randomized services
// against a latency/push model, and hand sequences for nesting, reset and level input.
module tb_intr_controller;
    import intr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        intr_in = 1'b0;
    logic [7:0]  pc = 8'h00;
    logic [3:0]  flags = 4'h0;
    logic        branch_pending = 1'b0;
    logic        pipe_empty = 1'b1;
    logic        rti_retire = 1'b0;
    logic        push_ready = 1'b1;
    logic        f_stall_req;
    logic        imem_addr_sel;
    logic        intr_ack;
    logic        intr_active;
    logic        push_valid;
    logic [7:0]  push_data;
    intr_state_t state_dbg;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] flags;
        int         br;
        int         pe;
        int         bp0;
        int         bp1;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
        int         exp_lat;
    } vec_t;

    vec_t       tbl[4];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         pcyc = 0;
    int         ack_cnt = 0;
    int         ack_cyc = 0;
    int         stall_cnt = 0;
    int         push_cnt = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       prev_ack = 1'b0;

    intr_controller dut (
        .clk            (clk),
        .reset          (reset),
        .intr_in        (intr_in),
        .pc             (pc),
        .flags          (flags),
        .branch_pending (branch_pending),
        .pipe_empty     (pipe_empty),
        .rti_retire     (rti_retire),
        .push_ready     (push_ready),
        .f_stall_req    (f_stall_req),
        .imem_addr_sel  (imem_addr_sel),
        .intr_ack       (intr_ack),
        .intr_active    (intr_active),
        .push_valid     (push_valid),
        .push_data      (push_data),
        .state_dbg      (state_dbg)
    );

    // clock / cycle counter / watchdog
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        pcyc++;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard / protocol monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            hold     = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (push_valid && hold) chk("push_hold", push_data, hold_data);
            hold      = push_valid && !push_ready;
            hold_data = push_data;
            if (push_valid && push_ready) begin
                push_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL push_extra: got %0h want none", push_data);
                end else begin
                    chk("push_data", push_data, exp_q.pop_front());
                end
            end
            if (f_stall_req) stall_cnt++;
            if (intr_ack) begin
                ack_cnt++;
                ack_cyc = pcyc;
                chk("ack_sel", imem_addr_sel, 1);
                chk("ack_stall", f_stall_req, 0);
            end
            if (prev_ack) chk("ack_pulse", intr_ack, 0);
            prev_ack = intr_ack;
        end
    end

    // Drives one service until intr_ack; k is the edge the latency counts from.
    // pc/flags carry junk except in the cycle DRAIN exits, so only that capture works.
    task automatic serve(input vec_t v, input int k);
        int dn = 0;
        int p0 = 0;
        int p1 = 0;
        int base = push_cnt;
        int ack0 = ack_cnt;
        int stall0 = stall_cnt;
        exp_q.push_back(v.exp_d0);
        exp_q.push_back(v.exp_d1);
        pc    = v.pc ^ 8'hFF;
        flags = ~v.flags;
        for (int t = 0; t < 200 && ack_cnt == ack0; t++) begin
            tick();
            rti_retire     = 1'b0;
            branch_pending = 1'b0;
            pipe_empty     = 1'b1;
            pc             = v.pc ^ 8'hFF;
            flags          = ~v.flags;
            push_ready     = 1'b1;
            if (f_stall_req && !push_valid) begin
                if (dn < v.br) branch_pending = 1'b1;
                else if (dn < v.br + v.pe) pipe_empty = 1'b0;
                else begin
                    pc    = v.pc;
                    flags = v.flags;
                end
                dn++;
            end
            if (push_valid) begin
                if (push_cnt == base) begin
                    push_ready = (p0 >= v.bp0);
                    p0++;
                end else begin
                    push_ready = (p1 >= v.bp1);
                    p1++;
                end
            end
        end
        chk("ack_seen", ack_cnt - ack0, 1);
        chk("latency", ack_cyc - k, v.exp_lat);
        chk("push_count", push_cnt - base, 2);
        chk("stall_cycles", stall_cnt - stall0, 3 + v.br + v.pe + v.bp0 + v.bp1);
        chk("active", intr_active, 1);
        exp_q.delete();
    endtask

    task automatic end_service();
        int s0;
        int a0;
        tick();
        tick();
        chk("active_hold", intr_active, 1);
        rti_retire = 1'b1;
        tick();
        rti_retire = 1'b0;
        chk("rti_active", intr_active, 0);
        chk("rti_stall", f_stall_req, 0);
        s0 = stall_cnt;
        a0 = ack_cnt;
        repeat (4) tick();
        chk("idle_quiet", (stall_cnt - s0) + (ack_cnt - a0), 0);
    endtask

    initial begin
        vec_t v;
        int   k;
        int   base;
        int   s0;
        int   a0;
        int   p0;

        tbl[0] = '{8'h23, 4'b1010, 0, 0, 0, 0, 8'h23, 8'h0A, 5};
        tbl[1] = '{8'h41, 4'b0001, 3, 2, 0, 0, 8'h41, 8'h01, 10};
        tbl[2] = '{8'hC8, 4'b1111, 0, 0, 2, 1, 8'hC8, 8'h0F, 8};
        tbl[3] = '{8'h00, 4'b0100, 1, 0, 1, 3, 8'h00, 8'h04, 10};

        // reset state
        #1 reset = 1'b0;
        repeat (3) tick();
        chk("rst_stall", f_stall_req, 0);
        chk("rst_sel", imem_addr_sel, 0);
        chk("rst_ack", intr_ack, 0);
        chk("rst_active", intr_active, 0);
        chk("rst_pvalid", push_valid, 0);
        chk("rst_pdata", push_data, 8'h00);
        chk("rst_state", state_dbg, S_IDLE);
        reset = 1'b1;
        repeat (3) tick();

        // table-driven services
        for (int i = 0; i < 4; i++) begin
            intr_in = 1'b1;
            k = pcyc + 1;
            serve(tbl[i], k);
            intr_in = 1'b0;
            end_service();
        end

        // randomized services against the latency/push model
        for (int i = 0; i < 8; i++) begin
            v.pc      = 8'($urandom_range(0, 255));
            v.flags   = 4'($urandom_range(0, 15));
            v.br      = $urandom_range(0, 3);
            v.pe      = $urandom_range(0, 3);
            v.bp0     = $urandom_range(0, 3);
            v.bp1     = $urandom_range(0, 3);
            v.exp_d0  = v.pc;
            v.exp_d1  = {4'h0, v.flags};
            v.exp_lat = 5 + v.br + v.pe + v.bp0 + v.bp1;
            intr_in = 1'b1;
            k = pcyc + 1;
            serve(v, k);
            intr_in = 1'b0;
            end_service();
        end

        // nested: edge during ACTIVE, RTI 10 cycles later re-enters DRAIN directly
        intr_in = 1'b1;
        k = pcyc + 1;
        serve(tbl[0], k);
        intr_in = 1'b0;
        repeat (3) tick();
        intr_in = 1'b1;
        a0 = ack_cnt;
        repeat (10) tick();
        chk("nest_still_active", intr_active, 1);
        chk("nest_no_ack", ack_cnt - a0, 0);
        v = '{8'h5C, 4'b0110, 0, 0, 0, 0, 8'h5C, 8'h06, 3};
        rti_retire = 1'b1;
        k = pcyc + 1;
        serve(v, k);
        intr_in = 1'b0;
        end_service();

        // reset mid-push with a pending request queued during DRAIN
        intr_in = 1'b1;
        pc = 8'h77;
        flags = 4'h3;
        branch_pending = 1'b1;
        for (int t = 0; t < 20 && !f_stall_req; t++) tick();
        chk("mid_drain", f_stall_req, 1);
        intr_in = 1'b0;
        repeat (3) tick();
        intr_in = 1'b1;
        repeat (3) tick();
        intr_in = 1'b0;
        exp_q.push_back(8'h77);
        base = push_cnt;
        branch_pending = 1'b0;
        push_ready = 1'b1;
        for (int t = 0; t < 20 && push_cnt == base; t++) tick();
        push_ready = 1'b0;
        tick();
        tick();
        chk("mid_pf_valid", push_valid, 1);
        chk("mid_pf_data", push_data, 8'h03);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", f_stall_req, 0);
        chk("mid_rst_pvalid", push_valid, 0);
        chk("mid_rst_pdata", push_data, 8'h00);
        chk("mid_rst_ack", intr_ack | imem_addr_sel | intr_active, 0);
        chk("mid_rst_state", state_dbg, S_IDLE);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        push_ready = 1'b1;
        s0 = stall_cnt;
        a0 = ack_cnt;
        p0 = push_cnt;
        repeat (20) tick();
        chk("post_rst_quiet", (stall_cnt - s0) + (ack_cnt - a0) + (push_cnt - p0), 0);

        // level: intr_in held high ~50 cycles gives exactly one service
        intr_in = 1'b1;
        k = pcyc + 1;
        a0 = ack_cnt;
        serve(tbl[0], k);
        repeat (40) tick();
        chk("level_one_ack", ack_cnt - a0, 1);
        end_service();
        intr_in = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
